// File: rtl/simd_operand_collector.sv
// Operand collector for the 32-lane SIMD integer ALU.
// Fetches warp-wide operands over a shared RF read port.
package pkg_opengpu;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MIN, ALU_MAX,
    ALU_MUL
  } alu_op_t;
endpackage

module simd_operand_collector
  import pkg_opengpu::*;
#(
  parameter int WARP_SIZE  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5,
  parameter int WARP_ID_W  = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid,
  output logic                             issue_ready,
  input  logic [WARP_ID_W-1:0]             issue_warp_id,
  input  logic [REG_ADDR_W-1:0]            issue_rs1,
  input  logic [REG_ADDR_W-1:0]            issue_rs2,
  input  logic                             issue_use_imm,
  input  logic [DATA_WIDTH-1:0]            issue_imm,
  input  alu_op_t                          issue_alu_op,
  input  logic [WARP_SIZE-1:0]             issue_active_mask,
  input  logic [REG_ADDR_W-1:0]            issue_rd,
  output logic                             rf_rd_req,
  output logic [WARP_ID_W-1:0]             rf_rd_warp_id,
  output logic [REG_ADDR_W-1:0]            rf_rd_addr,
  input  logic                             rf_rd_gnt,
  input  logic [WARP_SIZE*DATA_WIDTH-1:0]  rf_rd_data,
  output logic                             disp_valid,
  input  logic                             disp_ready,
  output logic [WARP_SIZE*DATA_WIDTH-1:0]  disp_operand_a,
  output logic [WARP_SIZE*DATA_WIDTH-1:0]  disp_operand_b,
  output alu_op_t                          disp_alu_op,
  output logic [WARP_SIZE-1:0]             disp_active_mask,
  output logic [WARP_ID_W-1:0]             disp_warp_id,
  output logic [REG_ADDR_W-1:0]            disp_rd,
  output logic                             drop_pulse
);

  localparam int VW = WARP_SIZE * DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_A, S_CAP_A,
    S_RD_B, S_CAP_B, S_DISP
  } state_t;

  state_t                  state_q;
  logic [WARP_ID_W-1:0]    warp_q;
  logic [REG_ADDR_W-1:0]   rs1_q;
  logic [REG_ADDR_W-1:0]   rs2_q;
  logic                    use_imm_q;
  alu_op_t                 op_q;
  logic [WARP_SIZE-1:0]    mask_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  logic [VW-1:0]           a_q;
  logic [VW-1:0]           b_q;
  logic                    drop_q;

  logic [VW-1:0]           lane_mask_d;
  logic [VW-1:0]           issue_lane_mask_d;
  logic [VW-1:0]           imm_vec_d;
  logic [VW-1:0]           rd_masked_d;
  logic                    issue_b_rd_d;
  logic                    held_b_rd_d;

  // Widen per-lane masks to full bit vectors for operand gating
  always_comb begin
    lane_mask_d       = '0;
    issue_lane_mask_d = '0;
    for (int i = 0; i < WARP_SIZE; i++) begin
      lane_mask_d[i*DATA_WIDTH +: DATA_WIDTH] =
        {DATA_WIDTH{mask_q[i]}};
      issue_lane_mask_d[i*DATA_WIDTH +: DATA_WIDTH] =
        {DATA_WIDTH{issue_active_mask[i]}};
    end
  end

  assign imm_vec_d   = {WARP_SIZE{issue_imm}} & issue_lane_mask_d;
  assign rd_masked_d = rf_rd_data & lane_mask_d;

  assign issue_b_rd_d = !issue_use_imm && (issue_rs2 != '0);
  assign held_b_rd_d  = !use_imm_q && (rs2_q != '0);

  // Control FSM plus the latched instruction and operand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      warp_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_imm_q <= 1'b0;
      op_q      <= alu_op_t'('0);
      mask_q    <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (issue_valid) begin
            warp_q    <= issue_warp_id;
            rs1_q     <= issue_rs1;
            rs2_q     <= issue_rs2;
            use_imm_q <= issue_use_imm;
            op_q      <= issue_alu_op;
            mask_q    <= issue_active_mask;
            rd_q      <= issue_rd;
            a_q       <= '0;
            b_q       <= issue_use_imm ? imm_vec_d : '0;
            if (issue_active_mask == '0) begin
              drop_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (issue_rs1 != '0) begin
              state_q <= S_RD_A;
            end else if (issue_b_rd_d) begin
              state_q <= S_RD_B;
            end else begin
              state_q <= S_DISP;
            end
          end
        end
        S_RD_A: begin
          if (rf_rd_gnt) state_q <= S_CAP_A;
        end
        S_CAP_A: begin
          a_q     <= rd_masked_d;
          state_q <= held_b_rd_d ? S_RD_B : S_DISP;
        end
        S_RD_B: begin
          if (rf_rd_gnt) state_q <= S_CAP_B;
        end
        S_CAP_B: begin
          b_q     <= rd_masked_d;
          state_q <= S_DISP;
        end
        S_DISP: begin
          if (disp_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign issue_ready   = (state_q == S_IDLE);
  assign rf_rd_req     = (state_q == S_RD_A) ||
                         (state_q == S_RD_B);
  assign rf_rd_warp_id = warp_q;
  assign rf_rd_addr    = (state_q == S_RD_B) ? rs2_q : rs1_q;

  assign disp_valid       = (state_q == S_DISP);
  assign disp_operand_a   = a_q;
  assign disp_operand_b   = b_q;
  assign disp_alu_op      = op_q;
  assign disp_active_mask = mask_q;
  assign disp_warp_id     = warp_q;
  assign disp_rd          = rd_q;
  assign drop_pulse       = drop_q;

endmodule
